// File: rtl/dlx_mem_pkg.sv
// ============================================================================
// dlx_mem_pkg : shared encodings and byte-lane helpers for the DLX memory port
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dlx_mem_pkg;

  localparam logic [1:0] MEMOP_BYTE = 2'b00;
  localparam logic [1:0] MEMOP_HALF = 2'b01;
  localparam logic [1:0] MEMOP_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Big-endian lanes: bit 3 of the mask is byte [31:24], i.e. address offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    case (op)
      MEMOP_BYTE: m = 4'b1000 >> off;
      MEMOP_HALF: m = off[1] ? 4'b0011 : 4'b1100;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      MEMOP_BYTE: mis = 1'b0;
      MEMOP_HALF: mis = off[0];
      default:    mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dlx_mem_array.sv
// ============================================================================
// dlx_mem_array : 2**ADDR_W x 32 synchronous RAM, byte write-enable, registered read
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dlx_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Read returns the pre-write contents when both occur on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dlx_mem_ctrl.sv
// ============================================================================
// dlx_mem_ctrl : MemRead/MemWrite responder with MemWait handshake over word RAM
//                Optional alignment checking and MemErr: DLX_MEM_ALIGN_CHECK_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dlx_mem_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemOP,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MemWait
`ifdef DLX_MEM_ALIGN_CHECK_EN
  ,
  output logic        MemErr
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic [3:0]        cnt;
  logic              req;
  logic              access;
  logic              misal;

  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [1:0]        lat_op;
  logic              lat_wr;

  logic              rd_valid;
  logic [1:0]        out_op;
  logic [1:0]        out_off;

  logic [3:0]        ram_we;
  logic              ram_re;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_aligned;

  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req = MemRead | MemWrite;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MemWait   = 1'b0;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          MemWait   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        MemWait = 1'b1;
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef DLX_MEM_ALIGN_CHECK_EN
  assign misal = is_misaligned(lat_op, lat_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  // Request captured at accept; write wins when both strobes are high.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && req) begin
      lat_addr  <= addr[ADDR_W+1:0];
      lat_wdata <= wdata;
      lat_op    <= MemOP;
      lat_wr    <= MemWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      cnt      <= 4'd0;
      rd_valid <= 1'b0;
    end else begin
      if (state == ST_IDLE && req) begin
        cnt <= CNT_LOAD;
      end else if (state == ST_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !lat_wr) begin
        rd_valid <= ~misal;
      end
    end
  end

  // Read-alignment selectors are kept apart from the request latch so rdata
  // stays put while the next request is in flight.
  always_ff @(posedge clock) begin
    if (access && !lat_wr) begin
      out_op  <= lat_op;
      out_off <= lat_addr[1:0];
    end
  end

`ifdef DLX_MEM_ALIGN_CHECK_EN
  logic err_lat;

  always_ff @(posedge clock) begin
    if (Reset) begin
      err_lat <= 1'b0;
    end else if (access) begin
      err_lat <= misal;
    end
  end

  assign MemErr = (state == ST_DONE) && err_lat;
`endif

  always_comb begin
    ram_wdata = lat_wdata;
    case (lat_op)
      MEMOP_BYTE: ram_wdata = {4{lat_wdata[7:0]}};
      MEMOP_HALF: ram_wdata = {2{lat_wdata[15:0]}};
      default:    ram_wdata = lat_wdata;
    endcase
  end

  // Reset on the access edge must abort the pending write.
  assign ram_we = (access && lat_wr && !misal && !Reset) ? lane_mask(lat_op, lat_addr[1:0]) : 4'b0000;
  assign ram_re = access && !lat_wr && !misal && !Reset;

  dlx_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clock),
    .re    (ram_re),
    .we    (ram_we),
    .idx   (lat_addr[ADDR_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign rd_shift = ram_q >> {~out_off, 3'b000};

  always_comb begin
    rd_aligned = ram_q;
    case (out_op)
      MEMOP_BYTE: rd_aligned = {24'h0, rd_shift[7:0]};
      MEMOP_HALF: rd_aligned = out_off[1] ? {16'h0, ram_q[15:0]} : {16'h0, ram_q[31:16]};
      default:    rd_aligned = ram_q;
    endcase
  end

  assign rdata = rd_valid ? rd_aligned : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dlx_mem_ctrl.sv
// ============================================================================
// tb_dlx_mem_ctrl : directed + random checks of dlx_mem_ctrl against a byte-array model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dlx_mem_ctrl;
  import dlx_mem_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int NBYTES  = 4 * (2 ** ADDR_W);

  logic        clock    = 1'b0;
  logic        Reset    = 1'b1;
  logic        MemRead  = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  MemOP    = 2'b00;
  logic [31:0] addr     = 32'h0;
  logic [31:0] wdata    = 32'h0;
  logic [31:0] rdata;
  logic        MemWait;
`ifdef DLX_MEM_ALIGN_CHECK_EN
  logic        MemErr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bm [NBYTES];
  logic [31:0] exp_rdata = 32'h0;

  always #5 clock = ~clock;

  dlx_mem_ctrl #(
    .ADDR_W (ADDR_W),
    .LATENCY(LATENCY)
  ) dut (
    .clock   (clock),
    .Reset   (Reset),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .MemOP   (MemOP),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .MemWait (MemWait)
`ifdef DLX_MEM_ALIGN_CHECK_EN
    ,
    .MemErr  (MemErr)
`endif
  );

  function automatic int op_bytes(input logic [1:0] op);
    return (op == 2'b00) ? 1 : (op == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] op, input logic [31:0] a);
`ifdef DLX_MEM_ALIGN_CHECK_EN
    return (op_bytes(op) == 2 && a[0]) || (op_bytes(op) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // First byte touched: address modulo RAM size, rounded down to the access size.
  function automatic int base_of(input logic [1:0] op, input logic [31:0] a);
    int b;
    b = int'(a % NBYTES);
    return b - (b % op_bytes(op));
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] op, input logic [31:0] a);
    logic [31:0] r;
    int b;
    r = 32'h0;
    b = base_of(op, a);
    for (int k = 0; k < op_bytes(op); k++) r = (r << 8) | {24'h0, bm[b + k]};
    return r;
  endfunction

  task automatic model_write(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    int b;
    int w;
    b = base_of(op, a);
    w = op_bytes(op);
    for (int k = 0; k < w; k++) bm[b + k] = wd[8*(w-1-k) +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete handshake; inputs are scrambled while the request is held to
  // show the DUT works only from what it captured at accept.
  task automatic access(input bit rd, input bit wr, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    int n;
    bit mis;
    mis = misaligned(op, a);
    if (rd && !wr) exp_rdata = mis ? 32'h0 : model_read(op, a);
    if (wr && !mis) model_write(op, a, wd);
    @(negedge clock);
    MemRead  = rd;
    MemWrite = wr;
    MemOP    = op;
    addr     = a;
    wdata    = wd;
    #1;
    n = 0;
    while (MemWait === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
      addr  = $urandom;
      wdata = $urandom;
      MemOP = 2'($urandom);
      #1;
    end
    chk("wait_cycles", n, LATENCY + 1);
    chk("rdata", rdata, exp_rdata);
`ifdef DLX_MEM_ALIGN_CHECK_EN
    chk("memerr", {31'h0, MemErr}, {31'h0, mis});
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      addr  = $urandom;
      wdata = $urandom;
      #1;
      chk("hold_wait", {31'h0, MemWait}, 32'h0);
      chk("hold_rdata", rdata, exp_rdata);
    end
    @(negedge clock);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    chk("release_wait", {31'h0, MemWait}, 32'h0);
  endtask

  initial begin
    int sel;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_wait", {31'h0, MemWait}, 32'h0);
`ifdef DLX_MEM_ALIGN_CHECK_EN
    chk("reset_memerr", {31'h0, MemErr}, 32'h0);
`endif
    Reset = 1'b0;

    // Give every RAM word a known value
    for (int w = 0; w < 2 ** ADDR_W; w++) access(1'b0, 1'b1, MEMOP_WORD, 32'(w * 4), $urandom, 0);

    // Reset in idle clears rdata, then a word read of address 0
    access(1'b1, 1'b0, MEMOP_WORD, 32'h40, 32'h0, 0);
    @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    #1;
    Reset = 1'b0;
    exp_rdata = 32'h0;
    chk("idle_reset_rdata", rdata, 32'h0);
    access(1'b1, 1'b0, MEMOP_WORD, 32'h0, 32'h0, 0);

    // Byte and half accesses against fixed expectations
    access(1'b0, 1'b1, MEMOP_WORD, 32'h10, 32'h11223344, 0);
    access(1'b1, 1'b0, MEMOP_BYTE, 32'h11, 32'h0, 0);
    chk("byte_read_0x11", rdata, 32'h00000022);
    access(1'b1, 1'b0, MEMOP_BYTE, 32'h13, 32'h0, 0);
    chk("byte_read_0x13", rdata, 32'h00000044);
    access(1'b0, 1'b1, MEMOP_HALF, 32'h12, 32'h0000BEEF, 0);
    access(1'b1, 1'b0, MEMOP_WORD, 32'h10, 32'h0, 0);
    chk("half_merge", rdata, 32'h1122BEEF);
    access(1'b1, 1'b0, MEMOP_HALF, 32'h10, 32'h0, 0);
    chk("half_read_hi", rdata, 32'h00001122);

    // Held write: single commit, stays DONE until request drops
    access(1'b0, 1'b1, MEMOP_WORD, 32'h30, 32'hA5A55A5A, 5);
    access(1'b1, 1'b0, MEMOP_WORD, 32'h30, 32'h0, 0);
    chk("held_write", rdata, 32'hA5A55A5A);

    // Reset during BUSY aborts the write, including on the access cycle
    for (int d = 1; d <= 2; d++) begin
      @(negedge clock);
      MemWrite = 1'b1;
      MemOP    = MEMOP_WORD;
      addr     = 32'h20;
      wdata    = 32'hDEADBEEF;
      #1;
      chk("busy_accept_wait", {31'h0, MemWait}, 32'h1);
      repeat (d) @(negedge clock);
      Reset    = 1'b1;
      MemWrite = 1'b0;
      @(negedge clock);
      #1;
      chk("busy_reset_wait", {31'h0, MemWait}, 32'h0);
      chk("busy_reset_rdata", rdata, 32'h0);
      Reset = 1'b0;
      exp_rdata = 32'h0;
      access(1'b1, 1'b0, MEMOP_WORD, 32'h20, 32'h0, 0);
    end

    // Unaligned word read: error with the check, aligned-down read without
    access(1'b1, 1'b0, MEMOP_WORD, 32'h22, 32'h0, 1);

    // Simultaneous strobes: write wins, rdata untouched
    access(1'b1, 1'b1, MEMOP_WORD, 32'h50, 32'hCAFEF00D, 0);
    access(1'b1, 1'b0, MEMOP_WORD, 32'h50, 32'h0, 0);
    chk("both_strobes", rdata, 32'hCAFEF00D);

    // High address bits wrap
    access(1'b0, 1'b1, MEMOP_WORD, 32'hFFFFF060, 32'h0BADC0DE, 0);
    access(1'b1, 1'b0, MEMOP_WORD, 32'h60, 32'h0, 0);
    chk("addr_wrap", rdata, 32'h0BADC0DE);

    // Random mix
    repeat (400) begin
      sel = $urandom_range(0, 3);
      access(sel != 1, sel != 0, 2'($urandom), $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
